seg_display_mux: RTL



---
 rtl/seg_display_mux_if.sv | 30 +++
 rtl/seg_display_mux.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/seg_display_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_mux_if
// Brief    : Game-logic side to seven-segment driver bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface seg_display_mux_if #(
    parameter int NUM_DIGITS = 4,
    parameter int VAL_BITS   = 14,
    parameter int CODE_BITS  = 4
);
    logic                            metronome_clk;
    logic                            mode;
    logic [NUM_DIGITS*CODE_BITS-1:0] arrow_codes;
    logic [VAL_BITS-1:0]             value;
    logic [6:0]                      seg;
    logic [NUM_DIGITS-1:0]           an;
    logic                            conv_busy;

    modport master (
        output metronome_clk, mode, arrow_codes, value,
        input  seg, an, conv_busy
    );

    modport slave (
        input  metronome_clk, mode, arrow_codes, value,
        output seg, an, conv_busy
    );
endinterface
`default_nettype wire

// File: rtl/seg_display_mux.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_mux
// Brief    : N-digit multiplexed seven-segment driver, arrow or numeric mode.
//            Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
// Revision : 1.0 - initial release
// ============================================================================
module seg_display_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int VAL_BITS    = 14,
    parameter int CODE_BITS   = 4
) (
    input  logic             clk,
    input  logic             rst,
    seg_display_mux_if.slave bus
);
    localparam int c_cnt_w  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_idx_w  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_bcd_w  = 4 * NUM_DIGITS;
    localparam int c_work_w = c_bcd_w + VAL_BITS;
    localparam int c_sh_w   = $clog2(VAL_BITS + 1);
    localparam logic [VAL_BITS-1:0]   c_max_val    = VAL_BITS'(10**NUM_DIGITS - 1);
    localparam logic [CODE_BITS-1:0]  c_code_blank = CODE_BITS'(14);
    localparam logic [NUM_DIGITS-1:0] c_an_one     = NUM_DIGITS'(1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    logic [c_cnt_w-1:0]                   r_refresh_cnt;
    logic [c_idx_w-1:0]                   r_scan_idx;
    logic [6:0]                           r_seg;
    logic [NUM_DIGITS-1:0]                r_an;
    logic                                 r_met_s1, r_met_s2, r_met_d;
    logic [NUM_DIGITS-1:0][CODE_BITS-1:0] r_codes;
    logic [1:0]                           r_state;
    logic                                 r_busy;
    logic [c_sh_w-1:0]                    r_shift_cnt;
    logic [c_work_w-1:0]                  r_work;
    logic [VAL_BITS-1:0]                  r_raw;
    logic [NUM_DIGITS-1:0][3:0]           r_bcd_disp;
    logic [VAL_BITS-1:0]                  r_last_value;

    logic [VAL_BITS-1:0]   w_clamped;
    logic [c_bcd_w-1:0]    w_bcd_adj;
    logic [3:0]            w_arrow_code;
    logic [3:0]            w_num_code;
    logic [3:0]            w_digit_code;
    logic [NUM_DIGITS-1:0] w_blank_mask;
    logic                  w_above_zero;

    function automatic logic [6:0] f_seg_map(input logic [3:0] code);
        case (code)
            4'd0:    f_seg_map = 7'b1000000;
            4'd1:    f_seg_map = 7'b1111001;
            4'd2:    f_seg_map = 7'b0100100;
            4'd3:    f_seg_map = 7'b0110000;
            4'd4:    f_seg_map = 7'b0011001;
            4'd5:    f_seg_map = 7'b0010010;
            4'd6:    f_seg_map = 7'b0000010;
            4'd7:    f_seg_map = 7'b1111000;
            4'd8:    f_seg_map = 7'b0000000;
            4'd9:    f_seg_map = 7'b0010000;
            4'd10:   f_seg_map = 7'b1111110;
            4'd11:   f_seg_map = 7'b1110111;
            4'd12:   f_seg_map = 7'b1101111;
            4'd13:   f_seg_map = 7'b1111011;
            4'd14:   f_seg_map = 7'b1111111;
            default: f_seg_map = 7'b0111111;
        endcase
    endfunction

    // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
        assign w_bcd_adj[gi*4 +: 4] = (r_work[VAL_BITS + gi*4 +: 4] >= 4'd5)
                                    ? r_work[VAL_BITS + gi*4 +: 4] + 4'd3
                                    : r_work[VAL_BITS + gi*4 +: 4];
    end

    always_comb begin
        w_clamped    = (bus.value > c_max_val) ? c_max_val : bus.value;
        w_blank_mask = '0;
        w_above_zero = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            w_above_zero    = w_above_zero && (r_bcd_disp[i] == 4'd0);
            w_blank_mask[i] = w_above_zero;
        end
`else
        w_blank_mask = '0;
`endif
        w_arrow_code = 4'(r_codes[r_scan_idx]);
        w_num_code   = w_blank_mask[r_scan_idx] ? 4'd14 : r_bcd_disp[r_scan_idx];
        w_digit_code = bus.mode ? w_num_code : w_arrow_code;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh_cnt <= '0;
            r_scan_idx    <= '0;
            r_seg         <= 7'b1111111;
            r_an          <= '1;
        end else begin
            r_seg <= f_seg_map(w_digit_code);
            r_an  <= ~(c_an_one << r_scan_idx);
            if (r_refresh_cnt == c_cnt_w'(REFRESH_DIV - 1)) begin
                r_refresh_cnt <= '0;
                r_scan_idx    <= (r_scan_idx == c_idx_w'(NUM_DIGITS - 1))
                               ? '0 : r_scan_idx + c_idx_w'(1);
            end else begin
                r_refresh_cnt <= r_refresh_cnt + c_cnt_w'(1);
            end
        end
    end

    // Metronome crosses in through two flops; the third flop detects the rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_met_s1 <= 1'b0;
            r_met_s2 <= 1'b0;
            r_met_d  <= 1'b0;
            r_codes  <= {NUM_DIGITS{c_code_blank}};
        end else begin
            r_met_s1 <= bus.metronome_clk;
            r_met_s2 <= r_met_s1;
            r_met_d  <= r_met_s2;
            if (r_met_s2 && !r_met_d)
                r_codes <= bus.arrow_codes;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_busy       <= 1'b0;
            r_shift_cnt  <= '0;
            r_work       <= '0;
            r_raw        <= '0;
            r_bcd_disp   <= '0;
            r_last_value <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.value != r_last_value) begin
                        r_raw       <= bus.value;
                        r_work      <= {{c_bcd_w{1'b0}}, w_clamped};
                        r_shift_cnt <= c_sh_w'(VAL_BITS);
                        r_busy      <= 1'b1;
                        r_state     <= c_st_shift;
                    end
                end
                c_st_shift: begin
                    r_work      <= {w_bcd_adj, r_work[VAL_BITS-1:0]} << 1;
                    r_shift_cnt <= r_shift_cnt - c_sh_w'(1);
                    if (r_shift_cnt == c_sh_w'(1))
                        r_state <= c_st_done;
                end
                c_st_done: begin
                    r_bcd_disp   <= r_work[c_work_w-1:VAL_BITS];
                    r_last_value <= r_raw;
                    r_busy       <= 1'b0;
                    r_state      <= c_st_idle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.seg       = r_seg;
    assign bus.an        = r_an;
    assign bus.conv_busy = r_busy;
endmodule
`default_nettype wire
